// File: rtl/dsc_mul_ctrl_if.sv
// Operand, result and multiplier-side signal bundle for dsc_mul_ctrl.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready handshakes.
interface dsc_mul_ctrl_if #(
    parameter int DW = 4,
    parameter int ZW = 8,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic          mul_rst;
    logic          mul_en;
    logic [ZW-1:0] mul_z;
    logic          mul_ov;
    logic          out_valid;
    logic          out_ready;
    logic [ZW-1:0] out_z;
    logic [CW-1:0] out_cycles;
    logic          out_timeout;

    // Controller side.
    modport slave (
        input  in_valid, in_a, in_b, mul_z, mul_ov, out_ready,
        output in_ready, mul_a, mul_b, mul_rst, mul_en,
               out_valid, out_z, out_cycles, out_timeout
    );

    // Environment side: operand source, multiplier and result sink.
    modport master (
        output in_valid, in_a, in_b, mul_z, mul_ov, out_ready,
        input  in_ready, mul_a, mul_b, mul_rst, mul_en,
               out_valid, out_z, out_cycles, out_timeout
    );
endinterface

// File: rtl/dsc_mul_ctrl.sv
// Sequences one operand pair through dsc_mul and collects product plus run length.
// Latency: accept -> 1 CLEAR -> RUN (until ov or TIMEOUT) -> SETTLE -> DONE; all outputs registered.
// Backpressure: in_ready only in IDLE; result held in DONE until out_valid && out_ready.
module dsc_mul_ctrl #(
    parameter int DW      = 4,
    parameter int ZW      = 8,
    parameter int CW      = 16,
    parameter int TIMEOUT = 300,
    parameter int SETTLE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    dsc_mul_ctrl_if.slave     bus,
    output logic              busy
);

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [DW-1:0] mul_a_q, mul_a_d;
    logic [DW-1:0] mul_b_q, mul_b_d;
    logic          mul_rst_q, mul_rst_d;
    logic          mul_en_q, mul_en_d;
    logic          out_valid_q, out_valid_d;
    logic [ZW-1:0] out_z_q, out_z_d;
    logic [CW-1:0] out_cycles_q, out_cycles_d;
    logic          out_timeout_q, out_timeout_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] settle_q, settle_d;

    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] settle_inc;

    // Saturating run counter step and settle counter step.
    always_comb begin
        cnt_inc    = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
        settle_inc = settle_q + CW'(1);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        in_ready_d    = in_ready_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mul_rst_d     = mul_rst_q;
        mul_en_d      = mul_en_q;
        out_valid_d   = out_valid_q;
        out_z_d       = out_z_q;
        out_cycles_d  = out_cycles_q;
        out_timeout_d = out_timeout_q;
        cnt_d         = cnt_q;
        settle_d      = settle_q;

        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                mul_rst_d  = 1'b1;
                mul_en_d   = 1'b0;
                if (bus.in_valid && in_ready_q) begin
                    mul_a_d    = bus.in_a;
                    mul_b_d    = bus.in_b;
                    in_ready_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Operands were latched on accept; release the multiplier now.
                mul_rst_d = 1'b0;
                mul_en_d  = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (bus.mul_ov) begin
                    // Completion wins over a timeout landing on the same cycle.
                    out_cycles_d  = cnt_inc;
                    out_timeout_d = 1'b0;
                    if (SETTLE == 0) begin
                        out_z_d     = bus.mul_z;
                        out_valid_d = 1'b1;
                        mul_en_d    = 1'b0;
                        mul_rst_d   = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        settle_d = '0;
                        state_d  = S_SETTLE;
                    end
                end else if (cnt_inc == TIMEOUT_C) begin
                    out_cycles_d  = TIMEOUT_C;
                    out_timeout_d = 1'b1;
                    out_z_d       = bus.mul_z;
                    out_valid_d   = 1'b1;
                    mul_en_d      = 1'b0;
                    mul_rst_d     = 1'b1;
                    state_d       = S_DONE;
                end
            end
            S_SETTLE: begin
                // Multiplier keeps running so z can absorb its final update.
                if (settle_inc == SETTLE_C) begin
                    out_z_d     = bus.mul_z;
                    out_valid_d = 1'b1;
                    mul_en_d    = 1'b0;
                    mul_rst_d   = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    settle_d = settle_inc;
                end
            end
            S_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_rst_q     <= 1'b1;
            mul_en_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_z_q       <= '0;
            out_cycles_q  <= '0;
            out_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            settle_q      <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            mul_rst_q     <= mul_rst_d;
            mul_en_q      <= mul_en_d;
            out_valid_q   <= out_valid_d;
            out_z_q       <= out_z_d;
            out_cycles_q  <= out_cycles_d;
            out_timeout_q <= out_timeout_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            settle_q      <= settle_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.mul_rst     = mul_rst_q;
    assign bus.mul_en      = mul_en_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_z       = out_z_q;
    assign bus.out_cycles  = out_cycles_q;
    assign bus.out_timeout = out_timeout_q;
    assign busy            = busy_q;

endmodule
